row_store_responder: RTL and testbench

On-chip responder for the row-burst read/write/refresh request protocol that the Life engine uses toward external DDR. It services 16-bit word requests from an on-chip block-RAM frame store instead of DDR, so the engine can run and be verified without the DDR controller. It sits in the clkDiv domain in place of the DDR controller. It acknowledges one word at a time, and the initiator advances its address and data on every acknowledge.

---
 rtl/row_store_responder.sv | 157 +++++++++++++++
 tb/tb_row_store_responder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/row_store_responder.sv
// row_store_responder
//   Stands in for the DDR controller on the clkDiv domain. Services the
//   row-burst word protocol (read / write / refresh) from an on-chip frame
//   store, one acknowledged word at a time.
//
// Ports
//   clkDiv, rst          clock; asynchronous active-high reset
//   read, readAddress    read request level and word address
//   readAcknowledge      one-cycle pulse; readData valid in the same cycle
//   readData             registered read word, held outside the acknowledge
//   write, writeAddress,
//   writeData            write request level, word address and word
//   writeAcknowledge     one-cycle pulse; word stored on this cycle's edge
//   refresh              refresh request (pulse or level), latched
//   busy                 high whenever the responder is not idle
//   addrError            sticky flag for any access beyond the frame store
module row_store_responder #(
  parameter int ADDR_W         = 24,
  parameter int DATA_W         = 16,
  parameter int DEPTH_LOG2     = 15,
  parameter int REFRESH_CYCLES = 4
) (
  input  logic              clkDiv,
  input  logic              rst,
  input  logic              read,
  input  logic [ADDR_W-1:0] readAddress,
  output logic              readAcknowledge,
  output logic [DATA_W-1:0] readData,
  input  logic              write,
  input  logic [ADDR_W-1:0] writeAddress,
  input  logic [DATA_W-1:0] writeData,
  output logic              writeAcknowledge,
  input  logic              refresh,
  output logic              busy,
  output logic              addrError
);

  localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    REFRESH,
    W_ACK,
    R_FETCH,
    R_ACK,
    GAP
  } state_t;

  state_t                 state;
  logic                   ref_pending;
  logic [CNT_W-1:0]       ref_cnt;
  logic [DATA_W-1:0]      mem [2**DEPTH_LOG2];

  logic [DEPTH_LOG2-1:0]  w_idx;
  logic [DEPTH_LOG2-1:0]  r_idx;
  logic                   w_oob;
  logic                   r_oob;

  assign w_idx = writeAddress[DEPTH_LOG2-1:0];
  assign r_idx = readAddress[DEPTH_LOG2-1:0];
  assign w_oob = |writeAddress[ADDR_W-1:DEPTH_LOG2];
  assign r_oob = |readAddress[ADDR_W-1:DEPTH_LOG2];

  // writeAcknowledge is high exactly while in W_ACK, so it doubles as the
  // write enable. Because reset clears it asynchronously, a word whose
  // W_ACK is cut short by rst is never committed.
  // NOTE: the frame store has no reset branch; clearing 32K words would
  // prevent block-RAM mapping and the contents are defined by writes anyway.
  always_ff @(posedge clkDiv) begin
    if (writeAcknowledge && !w_oob) begin
      mem[w_idx] <= writeData;
    end
  end

  // NOTE: all state lives in this one clocked block and uses non-blocking
  // assignments only, so every output is a register and no ordering
  // between statements can leak combinational paths.
  always_ff @(posedge clkDiv or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      ref_pending      <= 1'b0;
      ref_cnt          <= '0;
      readAcknowledge  <= 1'b0;
      writeAcknowledge <= 1'b0;
      readData         <= '0;
      busy             <= 1'b0;
      addrError        <= 1'b0;
    end else begin
      // Acknowledges are single-cycle pulses; the case below re-raises them
      // only on the transition into their state.
      readAcknowledge  <= 1'b0;
      writeAcknowledge <= 1'b0;
      ref_pending      <= ref_pending | refresh;

      case (state)
        IDLE: begin
          if (ref_pending) begin
            // Taking the refresh consumes the pending flag, but a refresh
            // arriving on this same cycle must stay latched.
            state       <= REFRESH;
            ref_pending <= refresh;
            ref_cnt     <= '0;
            busy        <= 1'b1;
          end else if (write) begin
            state            <= W_ACK;
            writeAcknowledge <= 1'b1;
            busy             <= 1'b1;
          end else if (read) begin
            state <= R_FETCH;
            busy  <= 1'b1;
          end
        end

        REFRESH: begin
          if (ref_cnt == CNT_W'(REFRESH_CYCLES - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            ref_cnt <= ref_cnt + 1'b1;
          end
        end

        W_ACK: begin
          if (w_oob) begin
            addrError <= 1'b1;
          end
          state <= GAP;
        end

        R_FETCH: begin
          readData        <= r_oob ? '0 : mem[r_idx];
          readAcknowledge <= 1'b1;
          if (r_oob) begin
            addrError <= 1'b1;
          end
          state <= R_ACK;
        end

        R_ACK: begin
          state <= GAP;
        end

        GAP: begin
          // Dead cycle lets the initiator's advanced address/data settle.
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_row_store_responder.sv
// tb_row_store_responder
//   Directed-plus-random bench for row_store_responder. An initiator model
//   advances address/data on every acknowledge; a word-addressed reference
//   memory predicts every read and burst lengths follow from the per-word
//   periods (3 cycles write, 4 cycles read, +5 per refresh taken mid-burst).
module tb_row_store_responder;

  logic        clkDiv = 1'b0;
  logic        rst    = 1'b1;
  logic        read   = 1'b0;
  logic        write  = 1'b0;
  logic        refresh = 1'b0;
  logic [23:0] readAddress  = '0;
  logic [23:0] writeAddress = '0;
  logic [15:0] writeData    = '0;
  logic        readAcknowledge;
  logic        writeAcknowledge;
  logic [15:0] readData;
  logic        busy;
  logic        addrError;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int tot_w      = 0;
  int tot_r      = 0;

  logic [15:0] model_mem [int];
  logic [15:0] wdata [64];

  int w_cnt, r_cnt, t_start, w_first, w_last, r_first, r_last;
  int base_w, base_r, n, ref_at, extra;
  logic [23:0] rbase;

  row_store_responder dut (
    .clkDiv           (clkDiv),
    .rst              (rst),
    .read             (read),
    .readAddress      (readAddress),
    .readAcknowledge  (readAcknowledge),
    .readData         (readData),
    .write            (write),
    .writeAddress     (writeAddress),
    .writeData        (writeData),
    .writeAcknowledge (writeAcknowledge),
    .refresh          (refresh),
    .busy             (busy),
    .addrError        (addrError)
  );

  always #5 clkDiv = ~clkDiv;

  always @(posedge clkDiv) cyc <= cyc + 1;

  always @(negedge clkDiv) begin
    if (writeAcknowledge) tot_w <= tot_w + 1;
    if (readAcknowledge)  tot_r <= tot_r + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Frame store holds 32768 words; anything beyond reads as zero.
  function automatic logic [15:0] expect_read(input logic [23:0] a);
    if (int'(a) >= 32768) return 16'h0000;
    if (model_mem.exists(int'(a))) return model_mem[int'(a)];
    return 16'h0000;
  endfunction

  task automatic sync();
    @(posedge clkDiv);
    #1;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) sync();
  endtask

  // Initiator: raises the requested levels, advances on each acknowledge,
  // drops each request after its n-th acknowledge. ref_at pulses refresh
  // during that write word; rst_at pulses rst during that read acknowledge.
  task automatic run_burst(input bit do_w, input bit do_r,
                           input logic [23:0] w_base, input logic [23:0] r_base,
                           input int cnt, input int ref_word, input int rst_at);
    bit got_w, got_r;
    w_cnt = 0; r_cnt = 0;
    w_first = -1; w_last = -1; r_first = -1; r_last = -1;
    writeAddress = w_base;
    writeData    = wdata[0];
    readAddress  = r_base;
    write        = do_w;
    read         = do_r;
    t_start      = cyc + 1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clkDiv);
      got_w = writeAcknowledge;
      got_r = readAcknowledge;
      if (got_w) begin
        if (w_first < 0) w_first = cyc;
        w_last = cyc;
        if (int'(writeAddress) < 32768) model_mem[int'(writeAddress)] = writeData;
        if (w_cnt + 1 == ref_word) refresh = 1'b1;
      end
      if (got_r) begin
        if (r_first < 0) r_first = cyc;
        r_last = cyc;
        check($sformatf("rdata@%0h", readAddress), 32'(readData), 32'(expect_read(readAddress)));
        if (r_cnt + 1 == rst_at) begin
          #1 rst = 1'b1;
          #1 check("rack_drop_on_rst", 32'(readAcknowledge), 32'd0);
          check("busy_drop_on_rst", 32'(busy), 32'd0);
          read  = 1'b0;
          write = 1'b0;
          @(posedge clkDiv);
          #1 rst = 1'b0;
          r_cnt++;
          return;
        end
      end
      @(posedge clkDiv);
      #1;
      refresh = 1'b0;
      if (got_w) begin
        w_cnt++;
        if (w_cnt < cnt) begin
          writeAddress = writeAddress + 24'd1;
          writeData    = wdata[w_cnt];
        end else begin
          write = 1'b0;
        end
      end
      if (got_r) begin
        r_cnt++;
        if (r_cnt < cnt) readAddress = readAddress + 24'd1;
        else read = 1'b0;
      end
      if ((!do_w || w_cnt >= cnt) && (!do_r || r_cnt >= cnt)) return;
    end
    compared++;
    mismatched++;
    $error("FAIL burst_timeout: observed w=%0d r=%0d acks expected %0d", w_cnt, r_cnt, cnt);
    write = 1'b0;
    read  = 1'b0;
  endtask

  initial begin
    // ---- reset, then idle with no requests
    repeat (3) @(posedge clkDiv);
    #1 rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clkDiv);
      check("idle_outputs", {11'd0, readAcknowledge, writeAcknowledge, busy, addrError, readData},
            32'd0);
    end

    // ---- row 3 write then read, 40 words
    for (int i = 0; i < 40; i++) wdata[i] = 16'hA500 + 16'(i);
    sync();
    base_w = tot_w;
    run_burst(1'b1, 1'b0, 24'h0000C0, 24'h0, 40, 0, 0);
    check("wr_first_latency", 32'(w_first - t_start), 32'd0);
    check("wr_burst_len", 32'(w_last - t_start + 3), 32'd120);
    idle(4);
    check("wr_ack_count", 32'(tot_w - base_w), 32'd40);

    base_r = tot_r;
    run_burst(1'b0, 1'b1, 24'h0, 24'h0000C0, 40, 0, 0);
    check("rd_first_latency", 32'(r_first - t_start), 32'd1);
    check("rd_burst_len", 32'(r_last - t_start + 3), 32'd160);
    idle(4);
    check("rd_ack_count", 32'(tot_r - base_r), 32'd40);

    // ---- refresh pulse during the 17th write word
    for (int i = 0; i < 40; i++) wdata[i] = 16'h5A00 + 16'(i);
    run_burst(1'b1, 1'b0, 24'h000100, 24'h0, 40, 17, 0);
    check("wr_refresh_burst_len", 32'(w_last - t_start + 3), 32'd125);
    idle(8);
    run_burst(1'b0, 1'b1, 24'h0, 24'h000100, 40, 0, 0);
    idle(4);

    // ---- read and write raised together at 0x40
    for (int i = 0; i < 8; i++) wdata[i] = 16'($urandom);
    base_w = tot_w;
    base_r = tot_r;
    run_burst(1'b1, 1'b1, 24'h000040, 24'h000040, 8, 0, 0);
    check("writes_before_reads", 32'(w_last < r_first), 32'd1);
    idle(4);
    check("mixed_wr_count", 32'(tot_w - base_w), 32'd8);
    check("mixed_rd_count", 32'(tot_r - base_r), 32'd8);

    // ---- random bursts with optional refresh
    for (int k = 0; k < 4; k++) begin
      n      = int'($urandom_range(4, 32));
      ref_at = int'($urandom_range(0, n));
      extra  = (ref_at > 0 && ref_at < n) ? 5 : 0;
      rbase  = 24'($urandom_range(32'h0200, 32'h7F00));
      for (int i = 0; i < n; i++) wdata[i] = 16'($urandom);
      run_burst(1'b1, 1'b0, rbase, 24'h0, n, ref_at, 0);
      check("rand_wr_len", 32'(w_last - t_start + 3), 32'(3 * n + extra));
      idle(8);
      run_burst(1'b0, 1'b1, 24'h0, rbase, n, 0, 0);
      check("rand_rd_len", 32'(r_last - t_start + 3), 32'(4 * n));
      idle(4);
    end

    // ---- out-of-range access
    wdata[0] = 16'h5A5A;
    run_burst(1'b1, 1'b0, 24'h000000, 24'h0, 1, 0, 0);
    idle(3);
    check("addr_err_clear", 32'(addrError), 32'd0);
    wdata[0] = 16'h1234;
    base_w = tot_w;
    run_burst(1'b1, 1'b0, 24'h008000, 24'h0, 1, 0, 0);
    idle(3);
    check("oob_wr_ack", 32'(tot_w - base_w), 32'd1);
    check("addr_err_set", 32'(addrError), 32'd1);
    run_burst(1'b0, 1'b1, 24'h0, 24'h000000, 1, 0, 0);
    idle(3);
    run_burst(1'b0, 1'b1, 24'h0, 24'h008000, 1, 0, 0);
    idle(10);
    check("addr_err_sticky", 32'(addrError), 32'd1);

    // ---- reset during R_ACK of word 5, then reissue
    run_burst(1'b0, 1'b1, 24'h0, 24'h0000C0, 40, 0, 5);
    @(negedge clkDiv);
    check("busy_after_rst", 32'(busy), 32'd0);
    check("addr_err_after_rst", 32'(addrError), 32'd0);
    idle(2);
    base_r = tot_r;
    run_burst(1'b0, 1'b1, 24'h0, 24'h0000C0, 40, 0, 0);
    check("reissue_latency", 32'(r_first - t_start), 32'd1);
    check("reissue_len", 32'(r_last - t_start + 3), 32'd160);
    idle(4);
    check("reissue_count", 32'(tot_r - base_r), 32'd40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
